// File: rtl/mult_arbiter.sv
// Round-robin arbiter that feeds one shared unsigned multiplier.
// Each accepted operand pair has a fixed flow: IDLE, CALC, DONE.
module mult_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SIZE-1:0] req_x,
  input  logic [NREQ*SIZE-1:0] req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [2*SIZE-1:0]    resp_p,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [SIZE-1:0]   r_x;
  logic [SIZE-1:0]   r_y;
  logic [IDW-1:0]    r_id;
  logic              r_resp_valid;
  logic [2*SIZE-1:0] r_resp_p;
  logic [IDW-1:0]    r_resp_id;

  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic              w_grant;
  logic [IDW-1:0]    w_next_ptr;
  logic [SIZE-1:0]   w_sel_x;
  logic [SIZE-1:0]   w_sel_y;
  logic [2*SIZE-1:0] w_prod;

  // Find the first valid requester at or above the pointer, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_grant = w_found && (r_state == IDLE) && !reset;

  assign w_next_ptr = (w_win == IDW'(NREQ - 1))
                    ? '0
                    : w_win + 1'b1;

  assign w_sel_x = req_x[w_win*SIZE +: SIZE];
  assign w_sel_y = req_y[w_win*SIZE +: SIZE];

  // The single shared multiplier, full-width unsigned.
  assign w_prod = {{SIZE{1'b0}}, r_x} * {{SIZE{1'b0}}, r_y};

  // Grant is combinational and one-hot; only the winner sees ready.
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // Sequencer: latch on accept, multiply, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_p     <= '0;
      r_resp_id    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_x      <= w_sel_x;
            r_y      <= w_sel_y;
            r_id     <= w_win;
            r_rr_ptr <= w_next_ptr;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_resp_p     <= w_prod;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
          r_state      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_p     = r_resp_p;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != IDLE) && !reset;

endmodule
